pipeline_stage1_fetch: RTL and testbench
========================================

// Module: pipeline_stage1_fetch
// PURPOSE
//  Instruction-fetch front end; produces the opcode stream and flag_pcraflip consumed by control stage 2.
//  Holds the two program counters PCRA0/PCRA1 and drives the fetch address from the active one.
//  Reacts to stage-2 control bits (pcra_flip, bus_request, break) with bubbles, bus hand-off and halt.
// PARAMETERS
//  WIDTH         8       opcode / main-bus data width
//  ADDR_WIDTH    16      program-counter and fetch-address width
//  NOP_OPCODE    8'h00   opcode injected as a bubble
//  RESET_CYCLES  2       NOP cycles emitted after reset release before first fetch (>=1)
// PORTS
//  clk              in   1           system clock, all state updates on posedge
//  reset            in   1           synchronous, active-high reset
//  mem_data_in      in   WIDTH       byte read from memory at fetch_addr
//  mainbus_in       in   WIDTH       main-bus data for PC loads
//  pcra_load_lo     in   1           write mainbus_in to low byte of inactive PC
//  pcra_load_hi     in   1           write mainbus_in to high byte of inactive PC
//  ctrl_pcra_flip   in   1           from stage 2 (controls[14]); swap active PC
//  ctrl_bus_request in   1           from stage 2 (controls[13]); hand bus to external master
//  ctrl_break       in   1           from stage 2 (controls[15]); halt fetch
//  resume           in   1           leave HALT
//  fetch_addr       out  ADDR_WIDTH  active PC, combinational from registers
//  fetch_en         out  1           memory read strobe
//  instruction      out  WIDTH       registered opcode to stage 2
//  flag_pcraflip    out  1           index of active PC (0=PCRA0); feeds stage-2 ROM address
//  bus_grant        out  1           external master owns the bus
//  halted           out  1           HALT state indicator
//  pcra0, pcra1     out  ADDR_WIDTH  PC register contents (debug/ALU path)
// BEHAVIOUR
//  Reset: pcra0=pcra1=0, flag_pcraflip=0, instruction=NOP_OPCODE, fetch_en=0, bus_grant=0,
//   halted=0, state=FLUSH with counter=RESET_CYCLES. Reset mid-operation aborts any state identically.
//  States: FLUSH, FETCH, FLIP, STALL, TURN, HALT. Priority per cycle: reset > break > bus_request > flip.
//  FLUSH: fetch_en=0, instruction<=NOP, counter decrements; at 1 -> FETCH. Control inputs ignored.
//  FETCH: fetch_en=1; on posedge instruction<=mem_data_in, active PC +1 (wraps FFFF->0000).
//   ctrl_break -> HALT; ctrl_bus_request -> STALL; ctrl_pcra_flip -> FLIP. In all three, this cycle's
//   byte is discarded (instruction<=NOP) and no PC increments.
//  FLIP: one cycle; flag_pcraflip toggles on entry edge; fetch_en=0, instruction<=NOP; -> FETCH.
//   Fetch resumes at new active PC with no skipped or repeated byte.
//  STALL: fetch_en=0, bus_grant=1 (registered, first asserted cycle after request seen),
//   instruction<=NOP, PCs hold. Leaves when ctrl_bus_request=0 -> TURN.
//  TURN: one cycle, bus_grant=0, fetch_en=0, instruction<=NOP; -> FETCH. Never grant and fetch together.
//  HALT: halted=1, fetch_en=0, instruction<=NOP; resume=1 -> FETCH next cycle. ctrl_* ignored in HALT.
//  PC loads: legal in every state except reset/FLUSH; always target the PC that is inactive before
//   this edge. Load coincident with flip: loaded byte lands in the PC that becomes active. lo and hi
//   together write both bytes with the same mainbus_in. Active PC is never loaded.
//  Loads and increments never touch the same register in one cycle (active vs inactive).
// STRUCTURE
//  Package pipeline_pkg: state encoding localparams, NOP_OPCODE default, PC width constant.
//  Sub-module pcra_counter: ADDR_WIDTH register with sync reset, load_lo/load_hi byte writes,
//   inc with wrap; instanced twice (PCRA0, PCRA1). FSM and output regs in this module.
// TESTING
//  Reset, mem returns addr[7:0]: 2 NOP cycles, then instruction 00,01,02...; fetch_addr 0000,0001...
//  pcra0=FFFF, fetch: after byte at FFFF, fetch_addr=0000 (wrap), no glitch in flag_pcraflip.
//  Load inactive PC lo=34,hi=12 then flip: one NOP bubble, flag_pcraflip=1, fetch_addr=1234, pcra0 held.
//  bus_request held 3 cycles: bus_grant high 3 cycles, 1 TURN cycle, fetch resumes at same address;
//   fetch_en and bus_grant never high together.
//  break at addr 0010: halted=1, NOPs, PC=0010 frozen; resume -> fetch at 0010.
//  reset asserted during STALL: bus_grant drops next edge, all outputs to reset values, FLUSH replays.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants and state encoding for the stage-1 instruction fetch front end.
package pipeline_pkg;

  localparam int unsigned DATA_W               = 8;
  localparam int unsigned PC_W                 = 16;
  localparam logic [7:0]  NOP_DEFAULT          = 8'h00;
  localparam int unsigned RESET_CYCLES_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_FLUSH = 3'd0,
    ST_FETCH = 3'd1,
    ST_FLIP  = 3'd2,
    ST_STALL = 3'd3,
    ST_TURN  = 3'd4,
    ST_HALT  = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/pipeline_stage1_fetch_pcra_counter.sv
// One program-counter register: byte-wise loads from the main bus, or increment with wrap.
module pcra_counter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_lo,
  input  logic                  load_hi,
  input  logic                  inc,
  input  logic [WIDTH-1:0]      d,
  output logic [ADDR_WIDTH-1:0] q
);

  // Loads win over increment; the top never requests both on one register.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load_lo || load_hi) begin
      if (load_lo) q[WIDTH-1:0] <= d;
      if (load_hi) q[ADDR_WIDTH-1 -: WIDTH] <= d;
    end else if (inc) begin
      q <= q + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_stage1_fetch.sv
// Instruction-fetch front end: dual PC, bubble/flip, bus hand-off and halt control.
module pipeline_stage1_fetch
  import pipeline_pkg::*;
#(
  parameter int unsigned     WIDTH        = DATA_W,
  parameter int unsigned     ADDR_WIDTH   = PC_W,
  parameter logic [WIDTH-1:0] NOP_OPCODE  = NOP_DEFAULT,
  parameter int unsigned     RESET_CYCLES = RESET_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      mem_data_in,
  input  logic [WIDTH-1:0]      mainbus_in,
  input  logic                  pcra_load_lo,
  input  logic                  pcra_load_hi,
  input  logic                  ctrl_pcra_flip,
  input  logic                  ctrl_bus_request,
  input  logic                  ctrl_break,
  input  logic                  resume,
  output logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_en,
  output logic [WIDTH-1:0]      instruction,
  output logic                  flag_pcraflip,
  output logic                  bus_grant,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] pcra0,
  output logic [ADDR_WIDTH-1:0] pcra1
);

  localparam int unsigned CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;

  fetch_state_e     state;
  logic [CNT_W-1:0] flush_cnt;

  logic fetch_go_c;
  logic load_ok_c;

  // A byte is consumed only in FETCH with no control bit pending.
  assign fetch_go_c = (state == ST_FETCH) && !ctrl_break && !ctrl_bus_request && !ctrl_pcra_flip;
  assign load_ok_c  = (state != ST_FLUSH);
  assign fetch_addr = flag_pcraflip ? pcra1 : pcra0;

  // Loads go to the PC that is inactive before the edge; increments to the active one.
  pcra_counter #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pcra0 (
    .clk     (clk),
    .reset   (reset),
    .load_lo (load_ok_c && pcra_load_lo && flag_pcraflip),
    .load_hi (load_ok_c && pcra_load_hi && flag_pcraflip),
    .inc     (fetch_go_c && !flag_pcraflip),
    .d       (mainbus_in),
    .q       (pcra0)
  );

  pcra_counter #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pcra1 (
    .clk     (clk),
    .reset   (reset),
    .load_lo (load_ok_c && pcra_load_lo && !flag_pcraflip),
    .load_hi (load_ok_c && pcra_load_hi && !flag_pcraflip),
    .inc     (fetch_go_c && flag_pcraflip),
    .d       (mainbus_in),
    .q       (pcra1)
  );

  // Fetch FSM; each output flop reflects the state being entered on this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_FLUSH;
      flush_cnt     <= CNT_W'(RESET_CYCLES);
      instruction   <= NOP_OPCODE;
      fetch_en      <= 1'b0;
      bus_grant     <= 1'b0;
      halted        <= 1'b0;
      flag_pcraflip <= 1'b0;
    end else begin
      instruction <= NOP_OPCODE;
      fetch_en    <= 1'b0;
      bus_grant   <= 1'b0;
      halted      <= 1'b0;
      case (state)
        ST_FLUSH: begin
          if (flush_cnt <= CNT_W'(1)) begin
            state    <= ST_FETCH;
            fetch_en <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - CNT_W'(1);
          end
        end
        ST_FETCH: begin
          if (ctrl_break) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (ctrl_bus_request) begin
            state     <= ST_STALL;
            bus_grant <= 1'b1;
          end else if (ctrl_pcra_flip) begin
            state         <= ST_FLIP;
            flag_pcraflip <= !flag_pcraflip;
          end else begin
            instruction <= mem_data_in;
            fetch_en    <= 1'b1;
          end
        end
        ST_FLIP: begin
          state    <= ST_FETCH;
          fetch_en <= 1'b1;
        end
        ST_STALL: begin
          if (ctrl_bus_request) begin
            bus_grant <= 1'b1;
          end else begin
            state <= ST_TURN;
          end
        end
        ST_TURN: begin
          state    <= ST_FETCH;
          fetch_en <= 1'b1;
        end
        ST_HALT: begin
          if (resume) begin
            state    <= ST_FETCH;
            fetch_en <= 1'b1;
          end else begin
            halted <= 1'b1;
          end
        end
        default: begin
          state     <= ST_FLUSH;
          flush_cnt <= CNT_W'(RESET_CYCLES);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_stage1_fetch.sv
// Self-checking bench for pipeline_stage1_fetch: directed scenarios plus random run vs a reference model.
module tb_pipeline_stage1_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  mem_data_in;
  logic [7:0]  mainbus_in;
  logic        pcra_load_lo, pcra_load_hi;
  logic        ctrl_pcra_flip, ctrl_bus_request, ctrl_break, resume;
  logic [15:0] fetch_addr;
  logic        fetch_en;
  logic [7:0]  instruction;
  logic        flag_pcraflip, bus_grant, halted;
  logic [15:0] pcra0, pcra1;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit [15:0] m_pc [2];
  bit        m_act;
  bit [7:0]  m_instr;
  bit        m_fetch, m_grant, m_halt, m_gap;
  int        m_flush;

  always #5 clk = ~clk;

  function automatic bit [7:0] mem_byte(input bit [15:0] a);
    return a[7:0] + a[15:8];
  endfunction

  assign mem_data_in = mem_byte(fetch_addr);

  pipeline_stage1_fetch dut (
    .clk              (clk),
    .reset            (reset),
    .mem_data_in      (mem_data_in),
    .mainbus_in       (mainbus_in),
    .pcra_load_lo     (pcra_load_lo),
    .pcra_load_hi     (pcra_load_hi),
    .ctrl_pcra_flip   (ctrl_pcra_flip),
    .ctrl_bus_request (ctrl_bus_request),
    .ctrl_break       (ctrl_break),
    .resume           (resume),
    .fetch_addr       (fetch_addr),
    .fetch_en         (fetch_en),
    .instruction      (instruction),
    .flag_pcraflip    (flag_pcraflip),
    .bus_grant        (bus_grant),
    .halted           (halted),
    .pcra0            (pcra0),
    .pcra1            (pcra1)
  );

  // Advance the reference model by one clock edge using the current inputs.
  task automatic model_edge();
    bit tgt;
    if (reset) begin
      m_pc[0] = '0; m_pc[1] = '0; m_act = 0; m_instr = 8'h00;
      m_fetch = 0; m_grant = 0; m_halt = 0; m_gap = 0; m_flush = 2;
      return;
    end
    tgt = !m_act;
    if (m_flush == 0) begin
      if (pcra_load_lo) m_pc[tgt][7:0]  = mainbus_in;
      if (pcra_load_hi) m_pc[tgt][15:8] = mainbus_in;
    end
    m_instr = 8'h00;
    if (m_flush > 1) begin
      m_flush--;
    end else if (m_flush == 1) begin
      m_flush = 0; m_fetch = 1;
    end else if (m_halt) begin
      if (resume) begin m_halt = 0; m_fetch = 1; end
    end else if (m_grant) begin
      if (!ctrl_bus_request) begin m_grant = 0; m_gap = 1; end
    end else if (m_gap) begin
      m_gap = 0; m_fetch = 1;
    end else if (m_fetch) begin
      if (ctrl_break) begin
        m_fetch = 0; m_halt = 1;
      end else if (ctrl_bus_request) begin
        m_fetch = 0; m_grant = 1;
      end else if (ctrl_pcra_flip) begin
        m_fetch = 0; m_act = !m_act; m_gap = 1;
      end else begin
        m_instr = mem_byte(m_pc[m_act]);
        m_pc[m_act] = m_pc[m_act] + 16'd1;
      end
    end
  endtask

  // One clock: edge, model update, then return at the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    reset = 0; mainbus_in = 8'h00; pcra_load_lo = 0; pcra_load_hi = 0;
    ctrl_pcra_flip = 0; ctrl_bus_request = 0; ctrl_break = 0; resume = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    step(); step();
    reset = 0;
    n_vec++;
    if ({instruction, fetch_en, flag_pcraflip, bus_grant, halted} !== {8'h00, 4'b0000}) begin
      n_err++; $display("FAIL reset_outputs: got instr=%h fe=%b flag=%b grant=%b halt=%b, want 00 0 0 0 0",
                        instruction, fetch_en, flag_pcraflip, bus_grant, halted);
    end
    n_vec++;
    if ({pcra0, pcra1, fetch_addr} !== 48'h0) begin
      n_err++; $display("FAIL reset_pcs: got pcra0=%h pcra1=%h addr=%h, want 0000", pcra0, pcra1, fetch_addr);
    end
  endtask

  task automatic test_sequential_fetch();
    step();
    n_vec++;
    if (fetch_en !== 1'b0 || instruction !== 8'h00) begin
      n_err++; $display("FAIL flush_second_cycle: got fe=%b instr=%h, want 0 00", fetch_en, instruction);
    end
    step();
    n_vec++;
    if (fetch_en !== 1'b1 || fetch_addr !== 16'h0000 || instruction !== 8'h00) begin
      n_err++; $display("FAIL first_fetch: got fe=%b addr=%h instr=%h, want 1 0000 00", fetch_en, fetch_addr, instruction);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      n_vec++;
      if (instruction !== 8'(k) || fetch_addr !== 16'(k + 1) || fetch_en !== 1'b1) begin
        n_err++; $display("FAIL seq_fetch[%0d]: got instr=%h addr=%h fe=%b, want %h %h 1",
                          k, instruction, fetch_addr, fetch_en, 8'(k), 16'(k + 1));
      end
    end
  endtask

  task automatic test_wrap();
    ctrl_pcra_flip = 1;
    step();
    ctrl_pcra_flip = 0;
    n_vec++;
    if (flag_pcraflip !== 1'b1 || fetch_en !== 1'b0 || fetch_addr !== 16'h0000) begin
      n_err++; $display("FAIL wrap_flip1: got flag=%b fe=%b addr=%h, want 1 0 0000", flag_pcraflip, fetch_en, fetch_addr);
    end
    pcra_load_lo = 1; pcra_load_hi = 1; mainbus_in = 8'hFF;
    step();
    pcra_load_lo = 0; pcra_load_hi = 0;
    n_vec++;
    if (pcra0 !== 16'hFFFF || pcra1 !== 16'h0000) begin
      n_err++; $display("FAIL wrap_load_both: got pcra0=%h pcra1=%h, want FFFF 0000", pcra0, pcra1);
    end
    ctrl_pcra_flip = 1;
    step();
    ctrl_pcra_flip = 0;
    step();
    n_vec++;
    if (fetch_addr !== 16'hFFFF || fetch_en !== 1'b1 || flag_pcraflip !== 1'b0) begin
      n_err++; $display("FAIL wrap_at_ffff: got addr=%h fe=%b flag=%b, want FFFF 1 0", fetch_addr, fetch_en, flag_pcraflip);
    end
    step();
    n_vec++;
    if (instruction !== 8'hFE || fetch_addr !== 16'h0000 || flag_pcraflip !== 1'b0) begin
      n_err++; $display("FAIL wrap_to_zero: got instr=%h addr=%h flag=%b, want FE 0000 0", instruction, fetch_addr, flag_pcraflip);
    end
    step();
    n_vec++;
    if (instruction !== 8'h00 || fetch_addr !== 16'h0001) begin
      n_err++; $display("FAIL wrap_after: got instr=%h addr=%h, want 00 0001", instruction, fetch_addr);
    end
  endtask

  task automatic test_load_flip();
    pcra_load_lo = 1; mainbus_in = 8'h34;
    step();
    pcra_load_lo = 0;
    n_vec++;
    if (pcra1 !== 16'h0034 || fetch_addr !== 16'h0002) begin
      n_err++; $display("FAIL load_lo: got pcra1=%h addr=%h, want 0034 0002", pcra1, fetch_addr);
    end
    pcra_load_hi = 1; mainbus_in = 8'h12;
    step();
    pcra_load_hi = 0;
    n_vec++;
    if (pcra1 !== 16'h1234 || fetch_addr !== 16'h0003) begin
      n_err++; $display("FAIL load_hi: got pcra1=%h addr=%h, want 1234 0003", pcra1, fetch_addr);
    end
    ctrl_pcra_flip = 1;
    step();
    ctrl_pcra_flip = 0;
    n_vec++;
    if (flag_pcraflip !== 1'b1 || instruction !== 8'h00 || fetch_en !== 1'b0 ||
        fetch_addr !== 16'h1234 || pcra0 !== 16'h0003) begin
      n_err++; $display("FAIL flip_bubble: got flag=%b instr=%h fe=%b addr=%h pcra0=%h, want 1 00 0 1234 0003",
                        flag_pcraflip, instruction, fetch_en, fetch_addr, pcra0);
    end
    step();
    step();
    n_vec++;
    if (instruction !== 8'h46 || fetch_addr !== 16'h1235 || pcra0 !== 16'h0003) begin
      n_err++; $display("FAIL flip_resume: got instr=%h addr=%h pcra0=%h, want 46 1235 0003", instruction, fetch_addr, pcra0);
    end
  endtask

  task automatic test_bus_request();
    ctrl_bus_request = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if (bus_grant !== 1'b1 || fetch_en !== 1'b0 || instruction !== 8'h00 || fetch_addr !== 16'h1235) begin
        n_err++; $display("FAIL stall[%0d]: got grant=%b fe=%b instr=%h addr=%h, want 1 0 00 1235",
                          k, bus_grant, fetch_en, instruction, fetch_addr);
      end
    end
    ctrl_bus_request = 0;
    step();
    n_vec++;
    if (bus_grant !== 1'b0 || fetch_en !== 1'b0) begin
      n_err++; $display("FAIL turn: got grant=%b fe=%b, want 0 0", bus_grant, fetch_en);
    end
    step();
    n_vec++;
    if (fetch_en !== 1'b1 || bus_grant !== 1'b0 || fetch_addr !== 16'h1235) begin
      n_err++; $display("FAIL stall_resume: got fe=%b grant=%b addr=%h, want 1 0 1235", fetch_en, bus_grant, fetch_addr);
    end
    step();
    n_vec++;
    if (instruction !== 8'h47) begin
      n_err++; $display("FAIL stall_byte: got instr=%h, want 47", instruction);
    end
  endtask

  task automatic test_break();
    pcra_load_lo = 1; mainbus_in = 8'h10;
    step();
    pcra_load_lo = 0; pcra_load_hi = 1; mainbus_in = 8'h00;
    step();
    pcra_load_hi = 0; ctrl_pcra_flip = 1;
    step();
    ctrl_pcra_flip = 0;
    step();
    n_vec++;
    if (fetch_addr !== 16'h0010 || fetch_en !== 1'b1 || flag_pcraflip !== 1'b0) begin
      n_err++; $display("FAIL break_setup: got addr=%h fe=%b flag=%b, want 0010 1 0", fetch_addr, fetch_en, flag_pcraflip);
    end
    ctrl_break = 1;
    step();
    ctrl_break = 0; ctrl_pcra_flip = 1; ctrl_bus_request = 1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (halted !== 1'b1 || fetch_en !== 1'b0 || instruction !== 8'h00 || fetch_addr !== 16'h0010 ||
          bus_grant !== 1'b0 || flag_pcraflip !== 1'b0) begin
        n_err++; $display("FAIL halt[%0d]: got halt=%b fe=%b instr=%h addr=%h grant=%b flag=%b, want 1 0 00 0010 0 0",
                          k, halted, fetch_en, instruction, fetch_addr, bus_grant, flag_pcraflip);
      end
      step();
    end
    ctrl_pcra_flip = 0; ctrl_bus_request = 0; resume = 1;
    step();
    resume = 0;
    n_vec++;
    if (halted !== 1'b0 || fetch_en !== 1'b1 || fetch_addr !== 16'h0010) begin
      n_err++; $display("FAIL resume: got halt=%b fe=%b addr=%h, want 0 1 0010", halted, fetch_en, fetch_addr);
    end
    step();
    n_vec++;
    if (instruction !== 8'h10 || fetch_addr !== 16'h0011) begin
      n_err++; $display("FAIL resume_byte: got instr=%h addr=%h, want 10 0011", instruction, fetch_addr);
    end
  endtask

  task automatic test_reset_in_stall();
    ctrl_bus_request = 1;
    step();
    n_vec++;
    if (bus_grant !== 1'b1) begin
      n_err++; $display("FAIL rst_stall_grant: got grant=%b, want 1", bus_grant);
    end
    reset = 1;
    step();
    reset = 0; ctrl_bus_request = 0;
    n_vec++;
    if (bus_grant !== 1'b0 || fetch_en !== 1'b0 || halted !== 1'b0 || instruction !== 8'h00 ||
        flag_pcraflip !== 1'b0 || pcra0 !== 16'h0 || pcra1 !== 16'h0) begin
      n_err++; $display("FAIL rst_stall_values: got grant=%b fe=%b halt=%b instr=%h flag=%b pcra0=%h pcra1=%h, want all zero",
                        bus_grant, fetch_en, halted, instruction, flag_pcraflip, pcra0, pcra1);
    end
    pcra_load_lo = 1; pcra_load_hi = 1; mainbus_in = 8'hAA;
    step();
    pcra_load_lo = 0; pcra_load_hi = 0;
    n_vec++;
    if (fetch_en !== 1'b0 || pcra0 !== 16'h0 || pcra1 !== 16'h0) begin
      n_err++; $display("FAIL flush_ignores_load: got fe=%b pcra0=%h pcra1=%h, want 0 0000 0000", fetch_en, pcra0, pcra1);
    end
    step();
    step();
    n_vec++;
    if (instruction !== 8'h00 || fetch_addr !== 16'h0001 || fetch_en !== 1'b1) begin
      n_err++; $display("FAIL flush_replay: got instr=%h addr=%h fe=%b, want 00 0001 1", instruction, fetch_addr, fetch_en);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      reset            = ($urandom_range(99) == 0);
      ctrl_break       = ($urandom_range(15) == 0);
      ctrl_bus_request = m_grant ? ($urandom_range(3) != 0) : ($urandom_range(9) == 0);
      ctrl_pcra_flip   = ($urandom_range(7) == 0);
      resume           = ($urandom_range(3) == 0);
      pcra_load_lo     = ($urandom_range(7) == 0);
      pcra_load_hi     = ($urandom_range(7) == 0);
      mainbus_in       = 8'($urandom);
      step();
      n_vec++;
      if (instruction !== m_instr || fetch_en !== m_fetch || bus_grant !== m_grant || halted !== m_halt ||
          flag_pcraflip !== m_act) begin
        n_err++; $display("FAIL rand_ctrl[%0d]: got instr=%h fe=%b grant=%b halt=%b flag=%b, want %h %b %b %b %b",
                          c, instruction, fetch_en, bus_grant, halted, flag_pcraflip,
                          m_instr, m_fetch, m_grant, m_halt, m_act);
      end
      n_vec++;
      if (pcra0 !== m_pc[0] || pcra1 !== m_pc[1] || fetch_addr !== m_pc[m_act]) begin
        n_err++; $display("FAIL rand_pc[%0d]: got pcra0=%h pcra1=%h addr=%h, want %h %h %h",
                          c, pcra0, pcra1, fetch_addr, m_pc[0], m_pc[1], m_pc[m_act]);
      end
      n_vec++;
      if (fetch_en === 1'b1 && bus_grant === 1'b1) begin
        n_err++; $display("FAIL rand_grant_fetch[%0d]: got fe=1 grant=1, want not both", c);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_sequential_fetch();
    test_wrap();
    test_load_flip();
    test_bus_request();
    test_break();
    test_reset_in_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
